sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; successor to the team's fixed 16x8 FIFO.
- Adds:
  - configurable width and depth
  - occupancy count output
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between a bursty producer and a consumer that may stall for several cycles.

---
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 tb/tb_sync_fifo_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags, sticky errors and optional FWFT read.
// Standard mode: 1-cycle read latency; FWFT: head visible combinationally. Full rejects writes, empty rejects reads.
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      write_en,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      read_en,
  input  logic                      clear_errors,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // Accept decisions use registered flags only, so a write into an empty FIFO cannot be read the same cycle.
  assign w_wr_ok = write_en && !r_full;
  assign w_rd_ok = read_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
    end else if (!w_wr_ok && w_rd_ok) begin
      w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == C_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= C_AFULL);
      r_aempty <= (w_count_nxt <= C_AEMPTY);
      // A new error outranks a coincident clear.
      if (write_en && r_full)      r_ovf <= 1'b1;
      else if (clear_errors)       r_ovf <= 1'b0;
      if (read_en && r_empty)      r_unf <= 1'b1;
      else if (clear_errors)       r_unf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Gate to zero while empty so the unreset storage never leaks onto data_out.
      assign data_out   = r_empty ? '0 : r_mem[r_rd_ptr];
      assign data_valid = !r_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_dv;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_dout <= '0;
          r_dv   <= 1'b0;
        end else begin
          r_dv <= w_rd_ok;
          if (w_rd_ok) r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign data_out   = r_dout;
      assign data_valid = r_dv;
    end
  endgenerate

  assign fifo_full    = r_full;
  assign fifo_empty   = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard-mode instance checked by a data scoreboard plus flag checks, and an FWFT instance.
module tb_sync_fifo_param;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // standard-mode instance
  logic       write_en = 1'b0, read_en = 1'b0, clear_errors = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] s_dout;
  logic       s_dv, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic [4:0] s_count;

  sync_fifo_param u_std (
    .clock(clock), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .clear_errors(clear_errors), .data_out(s_dout),
    .data_valid(s_dv), .fifo_full(s_full), .fifo_empty(s_empty),
    .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  // FWFT instance
  logic       f_we = 1'b0, f_re = 1'b0, f_clr = 1'b0;
  logic [7:0] f_din = 8'h00;
  logic [7:0] f_dout;
  logic       f_dv, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0] f_count;

  sync_fifo_param #(.FWFT(1)) u_fw (
    .clock(clock), .reset(reset), .write_en(f_we), .data_in(f_din),
    .read_en(f_re), .clear_errors(f_clr), .data_out(f_dout),
    .data_valid(f_dv), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every valid standard-mode output must match the oldest expected word.
  always @(negedge clock) begin
    if (!reset && s_dv) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h required=none at %0t", s_dout, $time);
      end else begin
        chk("sb_data", {24'h0, s_dout}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_count", {27'h0, s_count}, 0);
    chk("rst_empty", {31'h0, s_empty}, 1);
    chk("rst_aempty", {31'h0, s_aempty}, 1);
    chk("rst_full", {31'h0, s_full}, 0);
    chk("rst_afull", {31'h0, s_afull}, 0);
    chk("rst_dv", {31'h0, s_dv}, 0);
    chk("rst_dout", {24'h0, s_dout}, 0);
    reset = 1'b0;

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      write_en = 1'b1;
      data_in  = 8'(i);
      tick();
      chk("fill_count", {27'h0, s_count}, i + 1);
      chk("fill_afull", {31'h0, s_afull}, (i >= 11) ? 1 : 0);
      chk("fill_aempty", {31'h0, s_aempty}, (i <= 3) ? 1 : 0);
      chk("fill_full", {31'h0, s_full}, (i == 15) ? 1 : 0);
    end

    // overflow: 0xAA dropped
    data_in = 8'hAA;
    tick();
    write_en = 1'b0;
    chk("ovf_set", {31'h0, s_ovf}, 1);
    chk("ovf_count", {27'h0, s_count}, 16);

    for (int i = 0; i < 16; i++) begin
      read_en = 1'b1;
      sb_q.push_back(8'(i));
      tick();
      chk("rd_dv", {31'h0, s_dv}, 1);
    end
    read_en = 1'b0;
    chk("drain_empty", {31'h0, s_empty}, 1);
    chk("drain_count", {27'h0, s_count}, 0);
    chk("ovf_sticky", {31'h0, s_ovf}, 1);
    tick();
    chk("idle_dv", {31'h0, s_dv}, 0);
    chk("hold_dout", {24'h0, s_dout}, 32'h0F);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    chk("ovf_clear", {31'h0, s_ovf}, 0);

    // underflow, then clear coinciding with a new underflow
    read_en = 1'b1;
    tick();
    chk("unf_set", {31'h0, s_unf}, 1);
    chk("unf_dv", {31'h0, s_dv}, 0);
    clear_errors = 1'b1;
    tick();
    chk("unf_err_wins", {31'h0, s_unf}, 1);
    read_en = 1'b0;
    tick();
    clear_errors = 1'b0;
    chk("unf_clear", {31'h0, s_unf}, 0);

    // write+read into empty: write accepted, read rejected
    write_en = 1'b1;
    read_en  = 1'b1;
    data_in  = 8'h40;
    tick();
    read_en = 1'b0;
    chk("wr_empty_count", {27'h0, s_count}, 1);
    chk("wr_empty_unf", {31'h0, s_unf}, 1);
    chk("wr_empty_dv", {31'h0, s_dv}, 0);
    for (int i = 1; i < 8; i++) begin
      data_in = 8'h40 + 8'(i);
      tick();
    end
    chk("load8_count", {27'h0, s_count}, 8);

    // 20 simultaneous cycles across the pointer wrap
    read_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in = 8'h48 + 8'(k);
      sb_q.push_back(8'h40 + 8'(k));
      tick();
      chk("simul_count", {27'h0, s_count}, 8);
    end
    write_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back(8'h54 + 8'(k));
      tick();
    end
    read_en = 1'b0;
    chk("simul_empty", {31'h0, s_empty}, 1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;

    // write while full with read: write dropped, read accepted
    write_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'h80 + 8'(i);
      tick();
    end
    data_in = 8'hEE;
    read_en = 1'b1;
    sb_q.push_back(8'h80);
    tick();
    write_en = 1'b0;
    chk("full_rd_ovf", {31'h0, s_ovf}, 1);
    chk("full_rd_count", {27'h0, s_count}, 15);
    for (int i = 1; i < 16; i++) begin
      sb_q.push_back(8'h80 + 8'(i));
      tick();
    end
    read_en = 1'b0;
    tick();

    // reset mid-operation, asserted between edges
    write_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'hC0 + 8'(i);
      tick();
    end
    write_en = 1'b0;
    chk("mid_count10", {27'h0, s_count}, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", {27'h0, s_count}, 0);
    chk("async_empty", {31'h0, s_empty}, 1);
    chk("async_aempty", {31'h0, s_aempty}, 1);
    chk("async_afull", {31'h0, s_afull}, 0);
    chk("async_ovf", {31'h0, s_ovf}, 0);
    chk("async_dout", {24'h0, s_dout}, 0);
    tick();
    reset = 1'b0;
    write_en = 1'b1;
    data_in  = 8'h33;
    tick();
    write_en = 1'b0;
    read_en  = 1'b1;
    sb_q.push_back(8'h33);
    tick();
    read_en = 1'b0;
    chk("post_rst_dout", {24'h0, s_dout}, 32'h33);
    tick();

    // FWFT instance
    f_we  = 1'b1;
    f_din = 8'h5A;
    tick();
    f_din = 8'h5B;
    chk("fw_dout", {24'h0, f_dout}, 32'h5A);
    chk("fw_dv", {31'h0, f_dv}, 1);
    tick();
    f_we = 1'b0;
    chk("fw_head_held", {24'h0, f_dout}, 32'h5A);
    f_re = 1'b1;
    tick();
    chk("fw_next", {24'h0, f_dout}, 32'h5B);
    chk("fw_next_dv", {31'h0, f_dv}, 1);
    tick();
    f_re = 1'b0;
    chk("fw_pop_dv", {31'h0, f_dv}, 0);
    chk("fw_pop_empty", {31'h0, f_empty}, 1);
    chk("fw_unf", {31'h0, f_unf}, 0);

    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
